// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Owner tags steer each BRAM read response back to its requester.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int ADDR_W_DEF = 13;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port 1-cycle BRAM between instruction fetch and data.
// Data has priority until a waiting fetch has lost STARVE_MAX cycles in a row.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              flush,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    owner_e        own_q, own_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   if_hold_q, if_hold_d;
    logic [31:0]   d_hold_q, d_hold_d;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rst) begin
            if (d_req && (starve_q < SMAX)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bram_en   = if_gnt | d_gnt;
        bram_we   = (d_gnt && d_we) ? d_be : 4'b0000;
        bram_addr = if_gnt ? if_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];
        bram_din  = d_wdata;
    end

    assign stall_if  = if_req & ~if_gnt;
    assign stall_mem = d_req & ~d_gnt;

    // A flushed fetch still uses the BRAM cycle but its response is dropped
    always_comb begin
        own_d = OWN_NONE;
        if (if_gnt && !flush) begin
            own_d = OWN_IF;
        end else if (d_gnt && !d_we) begin
            own_d = OWN_D;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (starve_q < SMAX) begin
            starve_d = starve_q + CW'(1);
        end
    end

    assign if_rvalid = (own_q == OWN_IF);
    assign d_rvalid  = (own_q == OWN_D);

    always_comb begin
        if_hold_d = if_rvalid ? bram_dout : if_hold_q;
        d_hold_d  = d_rvalid ? bram_dout : d_hold_q;
    end

    assign if_rdata = if_rvalid ? bram_dout : if_hold_q;
    assign d_rdata  = d_rvalid ? bram_dout : d_hold_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            own_q     <= OWN_NONE;
            starve_q  <= '0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            own_q     <= own_d;
            starve_q  <= starve_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule
